// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_LAST_ADDR = 14;

    // All-zero word marks end of program when halt-on-zero is enabled.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory port, the decode-side valid/ready stage and the redirect request.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = fetch_pkg::DEF_ADDR_W,
    parameter int DATA_W = fetch_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_read_en;
    logic [DATA_W-1:0] imem_instr;

    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;

    modport master (
        output imem_addr, imem_read_en,
        input  imem_instr,
        output instr_out, instr_pc, instr_valid,
        input  instr_ready,
        input  redirect, redirect_addr
    );

    modport slave (
        input  imem_addr, imem_read_en,
        output imem_instr,
        input  instr_out, instr_pc, instr_valid,
        output instr_ready,
        output redirect, redirect_addr
    );

endinterface

// File: rtl/fetch_pc_counter.sv
// Program counter: load for start/redirect, increment per fetch, saturates at the last populated address.
module fetch_pc_counter
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LAST_ADDR = DEF_LAST_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = pc_reg;
        if (load) begin
            pc_next = load_val;
        end else if (inc_en && !at_last) begin
            pc_next = pc_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc      = pc_reg;
    assign at_last = (pc_reg == LAST_PC);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: drives the combinational instruction memory from the PC and registers
// each returned word into a valid/ready stage toward decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LAST_ADDR    = DEF_LAST_ADDR,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    instr_fetch_unit_if.master        bus,
    output logic                      halted,
    output logic                      err
);

    localparam logic [ADDR_W:0] LAST_EXT = (ADDR_W + 1)'(LAST_ADDR);

    fetch_state_t      state_reg, state_next;
    logic [DATA_W-1:0] instr_out_reg, instr_out_next;
    logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
    logic              valid_reg, valid_next;
    logic              err_reg, err_next;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;
    logic              at_last;
    logic              read_en;
    logic              redirect_hit;
    logic              redirect_ok;
    logic              zero_word;

    fetch_pc_counter #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc_en   (pc_inc),
        .pc       (pc),
        .at_last  (at_last)
    );

    assign redirect_hit = bus.redirect && ((state_reg == FETCH) || (state_reg == DRAIN));
    assign redirect_ok  = ({1'b0, bus.redirect_addr} <= LAST_EXT);
    assign zero_word    = (HALT_ON_ZERO != 0) && (bus.imem_instr == DATA_W'(NOP_WORD));

    always_comb begin
        state_next     = state_reg;
        instr_out_next = instr_out_reg;
        instr_pc_next  = instr_pc_reg;
        valid_next     = valid_reg;
        err_next       = err_reg;
        pc_load        = 1'b0;
        pc_load_val    = '0;
        pc_inc         = 1'b0;
        read_en        = 1'b0;

        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    pc_load    = 1'b1;
                    err_next   = 1'b0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                read_en = !valid_reg || bus.instr_ready;
                if (read_en) begin
                    if (zero_word) begin
                        // Sentinel is swallowed; the previous word was consumed this edge.
                        valid_next = 1'b0;
                        state_next = HALT;
                    end else begin
                        instr_out_next = bus.imem_instr;
                        instr_pc_next  = pc;
                        valid_next     = 1'b1;
                        pc_inc         = !at_last;
                        if (at_last) begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (valid_reg && bus.instr_ready) begin
                    valid_next = 1'b0;
                    state_next = HALT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Redirect wins over everything: the held word is dropped even if decode accepts it now.
        if (redirect_hit) begin
            read_en        = 1'b0;
            valid_next     = 1'b0;
            instr_out_next = instr_out_reg;
            instr_pc_next  = instr_pc_reg;
            pc_inc         = 1'b0;
            if (redirect_ok) begin
                pc_load     = 1'b1;
                pc_load_val = bus.redirect_addr;
                state_next  = FETCH;
            end else begin
                err_next   = 1'b1;
                state_next = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            instr_out_reg <= '0;
            instr_pc_reg  <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            instr_out_reg <= instr_out_next;
            instr_pc_reg  <= instr_pc_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.imem_read_en = read_en;
    assign bus.instr_out    = instr_out_reg;
    assign bus.instr_pc     = instr_pc_reg;
    assign bus.instr_valid  = valid_reg;
    assign halted           = (state_reg == HALT);
    assign err              = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural memory, scoreboard of accepted words, per-cycle vector table.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int LAST = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halted;
    logic err;

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch_unit #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .LAST_ADDR    (LAST),
        .HALT_ON_ZERO (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .halted (halted),
        .err    (err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] img [8];
    assign bus.imem_instr = mem[bus.imem_addr];

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic          ready;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic [DW-1:0] exp_instr;
        logic          exp_re;
    } vec_t;
    vec_t vt [8];

    int vec_count  = 0;
    int miss_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: a word counts as delivered on a valid&ready edge not cancelled by redirect.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            if (sb_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("FAIL unexpected_word: got pc=%0d instr=%h, required none", bus.instr_pc, bus.instr_out);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
                chk("sb_instr", bus.instr_out, e.word);
                $display("accept pc=%0d instr=%h", bus.instr_pc, bus.instr_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.pc   = AW'(i);
            e.word = mem[i];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic load_straight();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) mem[i] = img[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        img = '{32'h8c0c0000, 32'h8c0d0001, 32'h8c0e0002, 32'h8c0f0003,
                32'h018d4820, 32'h01cf5020, 32'h01494022, 32'hac080004};
        vt[0] = '{1'b1, 1'b0, 4'd0, 32'h0,         1'b1};
        vt[1] = '{1'b1, 1'b1, 4'd0, 32'h8c0c0000,  1'b1};
        vt[2] = '{1'b1, 1'b1, 4'd1, 32'h8c0d0001,  1'b1};
        vt[3] = '{1'b0, 1'b1, 4'd2, 32'h8c0e0002,  1'b0};
        vt[4] = '{1'b0, 1'b1, 4'd2, 32'h8c0e0002,  1'b0};
        vt[5] = '{1'b0, 1'b1, 4'd2, 32'h8c0e0002,  1'b0};
        vt[6] = '{1'b1, 1'b1, 4'd2, 32'h8c0e0002,  1'b1};
        vt[7] = '{1'b1, 1'b1, 4'd3, 32'h8c0f0003,  1'b1};

        bus.instr_ready   = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        load_straight();

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_re", 32'(bus.imem_read_en), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Straight-line run to the zero sentinel
        bus.instr_ready = 1'b1;
        push_range(0, 7);
        pulse_start();
        chk("start_addr", 32'(bus.imem_addr), 32'd0);
        chk("start_re", 32'(bus.imem_read_en), 32'd1);
        chk("start_valid", 32'(bus.instr_valid), 32'd0);
        repeat (8) tick();
        chk("run_not_halted", 32'(halted), 32'd0);
        chk("run_last_pc", 32'(bus.instr_pc), 32'd7);
        tick();
        chk("zero_halted", 32'(halted), 32'd1);
        chk("zero_dropped", 32'(bus.instr_valid), 32'd0);
        chk("sb_drained_run", sb_q.size(), 0);

        // Restart from HALT with backpressure on word 2
        push_range(0, 3);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            bus.instr_ready = vt[i].ready;
            @(negedge clk);
            chk("vt_valid", 32'(bus.instr_valid), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                chk("vt_pc", 32'(bus.instr_pc), 32'(vt[i].exp_pc));
                chk("vt_instr", bus.instr_out, vt[i].exp_instr);
            end
            chk("vt_re", 32'(bus.imem_read_en), 32'(vt[i].exp_re));
            tick();
        end

        // Redirect while fetching PC 5 (word at PC 4 is held and must be dropped)
        chk("pre_redir_addr", 32'(bus.imem_addr), 32'd5);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 4'd2;
        @(negedge clk);
        chk("redir_re", 32'(bus.imem_read_en), 32'd0);
        tick();
        bus.redirect = 1'b0;
        chk("redir_valid", 32'(bus.instr_valid), 32'd0);
        chk("redir_addr", 32'(bus.imem_addr), 32'd2);
        push_range(2, 7);
        wait_halt(20);
        chk("sb_drained_redir", sb_q.size(), 0);

        // Out-of-range redirect
        pulse_start();
        tick();
        chk("err_pre", 32'(err), 32'd0);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 4'd15;
        tick();
        bus.redirect = 1'b0;
        chk("bad_redir_err", 32'(err), 32'd1);
        chk("bad_redir_halted", 32'(halted), 32'd1);
        chk("bad_redir_valid", 32'(bus.instr_valid), 32'd0);

        // Restart clears err; start during FETCH is ignored
        push_range(0, 7);
        pulse_start();
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        tick();
        chk("pre_ign_addr", 32'(bus.imem_addr), 32'd2);
        pulse_start();
        chk("ign_start_addr", 32'(bus.imem_addr), 32'd3);
        chk("ign_start_pc", 32'(bus.instr_pc), 32'd2);
        wait_halt(20);
        chk("sb_drained_ign", sb_q.size(), 0);

        // Full memory: DRAIN after address 14, no wrap
        for (int i = 0; i < 15; i++) mem[i] = 32'h1000_0000 | 32'((i + 1) * 32'h0101);
        mem[15] = 32'hdead_beef;
        push_range(0, 14);
        pulse_start();
        repeat (15) tick();
        chk("drain_valid", 32'(bus.instr_valid), 32'd1);
        chk("drain_pc", 32'(bus.instr_pc), 32'd14);
        chk("drain_re", 32'(bus.imem_read_en), 32'd0);
        chk("drain_not_halted", 32'(halted), 32'd0);
        chk("drain_no_wrap", 32'(bus.imem_addr), 32'd14);
        tick();
        chk("drain_halted", 32'(halted), 32'd1);
        chk("drain_valid_clr", 32'(bus.instr_valid), 32'd0);
        chk("halt_no_wrap", 32'(bus.imem_addr), 32'd14);
        chk("sb_drained_full", sb_q.size(), 0);

        // Asynchronous reset mid-run
        load_straight();
        push_range(0, 0);
        pulse_start();
        tick();
        tick();
        chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        chk("pre_rst_pc", 32'(bus.instr_pc), 32'd1);
        chk("pre_rst_re", 32'(bus.imem_read_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_instr", bus.instr_out, 32'd0);
        chk("arst_pc", 32'(bus.instr_pc), 32'd0);
        chk("arst_re", 32'(bus.imem_read_en), 32'd0);
        chk("arst_addr", 32'(bus.imem_addr), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        chk("sb_drained_rst", sb_q.size(), 0);
        tick();
        push_range(0, 7);
        pulse_start();
        chk("post_rst_addr", 32'(bus.imem_addr), 32'd0);
        wait_halt(20);
        chk("sb_drained_post", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch initiator for the single-cycle instruction memory. It owns the program counter and drives the memory's address/read-enable pair. Each returned 32-bit word is registered into a valid/ready output stage feeding the decode block. It handles start, backpressure, branch redirect and end-of-program halt.

## Interface
- Parameters:
  - `ADDR_W`, default 4: instruction memory address width.
  - `DATA_W`, default 32: instruction width.
  - `LAST_ADDR`, default 14: highest populated memory address; fetch never goes beyond it.
  - `HALT_ON_ZERO`, default 1: when 1, a fetched all-zero word is the end-of-program sentinel.
- Ports:
  - `clk` input 1: single clock, all logic on the rising edge.
  - `rst_n` input 1: asynchronous, active-low reset.
  - `start` input 1: begin fetching from address 0; honoured only in IDLE or HALT.
  - `imem_addr` output ADDR_W: memory address, equal to the PC.
  - `imem_read_en` output 1: memory read enable.
  - `imem_instr` input DATA_W: combinational memory read data.
  - `instr_out` output DATA_W: registered instruction to decode.
  - `instr_pc` output ADDR_W: address `instr_out` was fetched from.
  - `instr_valid` output 1: `instr_out` is valid.
  - `instr_ready` input 1: decode accepts `instr_out` this cycle.
  - `redirect` input 1: branch/jump; flush the output stage and refetch.
  - `redirect_addr` input ADDR_W: new PC.
  - `halted` output 1: in HALT state.
  - `err` output 1: sticky; set when a redirect target is above `LAST_ADDR`; cleared by `start`.

## Operation
- States are IDLE, FETCH, DRAIN and HALT.
- **IDLE:** `imem_read_en` is 0. On `start`: PC is set to 0 and the state moves to FETCH.
- **FETCH:**
  - `imem_read_en = !instr_valid || instr_ready`. This is combinational from state, `instr_valid`, `instr_ready` and `redirect`.
  - `imem_addr` = PC.
  - On an edge with `imem_read_en` = 1, the fetch depends on the word returned:
    - Zero word with `HALT_ON_ZERO` = 1: the word is discarded. `instr_valid` is cleared (the prior word was consumed this cycle). The state moves to HALT.
    - Otherwise: `instr_out` is loaded with `imem_instr`, `instr_pc` with PC, and `instr_valid` is set to 1. PC advances to PC+1. If PC == `LAST_ADDR`, the state moves to DRAIN instead and PC does not wrap.
  - When `imem_read_en` = 0 because of backpressure: PC and the output stage hold.
- **DRAIN:** `imem_read_en` is 0. When `instr_valid && instr_ready`: `instr_valid` goes to 0 and the state moves to HALT.
- **HALT:** `halted` = 1 and `imem_read_en` = 0. On `start`: PC is set to 0, `err` is cleared and the state moves to FETCH.
- **Redirect** (FETCH or DRAIN only; ignored in IDLE and HALT):
  - `instr_valid` is set to 0 and the held word is dropped, even if `instr_ready` is high that cycle.
  - `imem_read_en` is 0 in the redirect cycle.
  - If `redirect_addr` <= `LAST_ADDR`: PC is set to `redirect_addr` and the state moves to FETCH.
  - Otherwise: `err` is set to 1 and the state moves to HALT.
- **Priority:** `redirect` > fetch/handshake. `start` outside IDLE/HALT is ignored.
- **Reset** (asynchronous, any state, mid-fetch included):
  - State returns to IDLE.
  - PC, `instr_out`, `instr_pc`, `instr_valid`, `halted` and `err` all go to 0.
  - `imem_read_en` goes to 0 immediately.

## Timing
- The memory is combinational: address and data are in the same cycle, and the word is sampled on the closing edge.
- Start latency: `start` is sampled at edge E0. Address 0 is driven in the following cycle. `instr_valid` = 1 after edge E1.
- Throughput: one instruction per cycle while `instr_ready` = 1.
- A stall costs no cycles beyond the stall itself. No word is lost or duplicated across backpressure.
- Redirect: the redirect is seen at edge R0. `redirect_addr` is fetched in the next cycle. The first new `instr_valid` appears after edge R1.
- `instr_out` and `instr_pc` are stable while `instr_valid && !instr_ready`.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` (IDLE, FETCH, DRAIN, HALT);
  - `ADDR_W`, `DATA_W`, `LAST_ADDR` defaults;
  - `NOP_WORD` = 32'h00000000.
- Sub-module `fetch_pc_counter`: PC register with load (start/redirect), increment enable, and an `at_last` flag (PC == `LAST_ADDR`).
- The top level holds the FSM, the output register and the `err` flag.

## Test plan
- **Straight-line run:** memory image words 0..7 = 8c0c0000, 8c0d0001, 8c0e0002, 8c0f0003, 018d4820, 01cf5020, 01494022, ac080004, then zeros; `instr_ready` held at 1; `start` pulsed.
  - Required: 8 consecutive valid words with `instr_pc` 0..7.
  - Required: the zero word at address 8 is never presented and `halted` = 1 after the address-8 fetch edge.
- **Backpressure:** `instr_ready` = 0 for 3 cycles while `instr_out` = 8c0e0002.
  - Required: output and `instr_pc` = 2 hold and `imem_read_en` = 0.
  - Required: after release the sequence resumes at 8c0f0003 with no loss or duplication.
- **Redirect:** during a fetch at PC 5, redirect to 2.
  - Required: the pending word is dropped and the next valid word is 8c0e0002 with `instr_pc` = 2.
  - Redirect to 15: required `err` = 1 and `halted` = 1.
- **Full memory:** image with all 15 words nonzero.
  - Required: `instr_pc` runs 0..14, the state enters DRAIN and then HALT after address 14 is consumed, and PC never wraps to 0.
- **Reset mid-operation:** assert `rst_n` = 0 mid-run with `instr_valid` = 1.
  - Required: all outputs go to 0 asynchronously.
  - Required: after release and `start`, fetch restarts at address 0.
- **Restart and ignored start:** `start` in HALT.
  - Required: refetch from 0 and `err` cleared.
  - `start` pulsed in FETCH: required no effect on PC.
